// File: rtl/card_pkg.sv
// Shared constants, LFSR step function and FSM state type for the deck dealer.
package card_pkg;

    localparam int CARD_COUNT = 52;
    localparam int CARD_W     = 6;
    localparam int LFSR_W     = 16;

    localparam int LFSR_TAP0 = 15;
    localparam int LFSR_TAP1 = 13;
    localparam int LFSR_TAP2 = 11;
    localparam int LFSR_TAP3 = 10;

    localparam logic [LFSR_W-1:0] LFSR_ZERO_SUB = 16'h0001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHUFFLE = 2'd1,
        ST_READY   = 2'd2
    } dealer_state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[LFSR_TAP0] ^ v[LFSR_TAP1] ^ v[LFSR_TAP2] ^ v[LFSR_TAP3]};
    endfunction

endpackage

// File: rtl/dealer_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load; a zero seed would lock up, so it is swapped for 1.
module dealer_lfsr16
    import card_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= LFSR_ZERO_SUB;
        end else if (load) begin
            q <= (load_val == '0) ? LFSR_ZERO_SUB : load_val;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/deck_dealer.sv
// Shuffle-and-deal controller: rejection-sampled LFSR shuffle into a deck array,
// then one registered card per deal request.
module deck_dealer
    import card_pkg::*;
#(
    parameter int CARDS      = 52,
    parameter int REJECT_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] seed,
    input  logic              shuffle_start,
    input  logic              deal_req,
    output logic              busy,
    output logic              deck_ready,
    output logic              deal_valid,
    output logic [CARD_W-1:0] deal_card,
    output logic [CARD_W-1:0] cards_left,
    output logic              deck_empty
);

    localparam int REJ_W = $clog2(REJECT_MAX + 1);

    dealer_state_t state, state_nxt;

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] cand_mod;
    logic [CARD_W-1:0] cand;
    logic [CARD_W-1:0] low_idx;
    logic [CARD_W-1:0] place_card;
    logic [CARDS-1:0]  used;
    logic [CARD_W-1:0] fill;
    logic [CARD_W-1:0] ptr;
    logic [CARD_W-1:0] left;
    logic [REJ_W-1:0]  rej;
    logic [CARD_W-1:0] deck [CARDS];
    logic              start_acc, pick_fb, place, last_place, deal_go;
    logic              vld_p1;
    logic [CARD_W-1:0] card_p1;

    dealer_lfsr16 u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (start_acc),
        .load_val (seed),
        .step     (state == ST_SHUFFLE),
        .q        (lfsr_q)
    );

    // Lowest unused card, used only when the reject budget is exhausted.
    always_comb begin
        low_idx = '0;
        for (int i = CARDS - 1; i >= 0; i--) begin
            if (!used[i]) low_idx = CARD_W'(i);
        end
    end

    always_comb begin
        cand_mod   = lfsr_q % LFSR_W'(CARDS);
        cand       = cand_mod[CARD_W-1:0] + CARD_W'(1);
        start_acc  = shuffle_start && (state != ST_SHUFFLE);
        pick_fb    = (rej == REJ_W'(REJECT_MAX));
        place      = (state == ST_SHUFFLE) && (pick_fb || !used[cand - CARD_W'(1)]);
        place_card = pick_fb ? (low_idx + CARD_W'(1)) : cand;
        last_place = place && (fill == CARD_W'(CARDS - 1));
        deal_go    = (state == ST_READY) && !shuffle_start && deal_req && (left != '0);

        state_nxt = state;
        case (state)
            ST_IDLE:    if (start_acc) state_nxt = ST_SHUFFLE;
            ST_SHUFFLE: if (last_place) state_nxt = ST_READY;
            ST_READY:   if (shuffle_start) state_nxt = ST_SHUFFLE;
            default:    state_nxt = ST_IDLE;
        endcase

        busy       = (state == ST_SHUFFLE);
        deck_ready = (state == ST_READY);
        deck_empty = (state == ST_READY) && (left == '0);
        deal_valid = vld_p1;
        deal_card  = card_p1;
        cards_left = left;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            used    <= '0;
            fill    <= '0;
            rej     <= '0;
            ptr     <= '0;
            left    <= '0;
            vld_p1  <= 1'b0;
            card_p1 <= '0;
        end else begin
            // Deal stage: output register p1
            vld_p1 <= deal_go;
            if (deal_go) begin
                card_p1 <= deck[ptr];
                ptr     <= ptr + CARD_W'(1);
                left    <= left - CARD_W'(1);
            end
            if (start_acc) begin
                used <= '0;
                fill <= '0;
                rej  <= '0;
                ptr  <= '0;
                left <= '0;
            end else if (state == ST_SHUFFLE) begin
                if (place) begin
                    used[place_card - CARD_W'(1)] <= 1'b1;
                    fill <= fill + CARD_W'(1);
                    rej  <= '0;
                    if (last_place) begin
                        ptr  <= '0;
                        left <= CARD_W'(CARDS);
                    end
                end else begin
                    rej <= rej + REJ_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (place) deck[fill] <= place_card;
    end

endmodule

// File: doc/deck_dealer.md
# deck_dealer

Shuffle-and-deal controller for the card game. It steps a 16-bit LFSR, maps each value to a card 1..52 and rejects duplicates against a used-card mask. It builds a 52-entry permutation, then serves cards one per request through a valid-pulse handshake. It sits between the game FSM, which issues shuffle and deal requests, and the random source, which it owns and sequences.

## Interface
Parameters:
- `CARDS`, 52: deck size; card codes are 1..CARDS.
- `REJECT_MAX`, 255: consecutive duplicate draws before the fallback pick.

Ports:
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: reset; one clock; synchronous, active-high.
- `seed`  in  16: LFSR load value, sampled on `shuffle_start`.
- `shuffle_start`  in  1: request a new shuffle; single-cycle pulse.
- `deal_req`  in  1: request the next card.
- `busy`  out  1: high while in SHUFFLE.
- `deck_ready`  out  1: high in READY.
- `deal_valid`  out  1: one-cycle pulse; `deal_card` is valid.
- `deal_card`  out  6: dealt card code, 1..52.
- `cards_left`  out  6: undealt cards, 0..52.
- `deck_empty`  out  1: high in READY when `cards_left` is 0.

## Operation
- States: IDLE, SHUFFLE, READY.
- IDLE → SHUFFLE on `shuffle_start`:
  - Load the LFSR with `seed`; a zero seed is replaced by 16'h0001 (lock-up guard).
  - Clear the 52-bit used mask, the fill count and the reject count.
- SHUFFLE, one candidate per cycle:
  - Candidate = (lfsr mod 52) + 1, computed on the 16-bit value and truncated to 6 bits.
  - If unused: `deck[fill]` ← candidate, set the used bit, increment fill, clear the reject count.
  - If used: increment the reject count.
  - When the reject count reaches REJECT_MAX, take the lowest-index unused card instead and clear the count. This guarantees termination.
  - LFSR steps every SHUFFLE cycle: `bit0` ← b15^b13^b11^b10, bits shift up by one.
  - When fill reaches 52: go to READY, deal pointer ← 0, `cards_left` ← 52.
- READY:
  - `deal_req` with `cards_left` > 0: next cycle `deal_valid`=1 and `deal_card` = `deck[ptr]`; ptr++ and `cards_left`--.
  - `deal_req` with `cards_left` = 0: no `deal_valid`; `deck_empty` stays 1.
  - `shuffle_start` re-enters SHUFFLE with a fresh seed. It takes priority over a simultaneous `deal_req`, which is dropped.
- Ignored inputs:
  - `shuffle_start` in SHUFFLE.
  - `deal_req` in IDLE or SHUFFLE; `deal_valid` stays 0.
- `rst` at any time, including mid-shuffle or mid-deal:
  - State → IDLE; LFSR ← 16'h0001; mask, counters and pointer ← 0.
  - Deck contents are don't-care.
- Output values after reset: `busy`=0, `deck_ready`=0, `deal_valid`=0, `deal_card`=0, `cards_left`=0, `deck_empty`=0.
- Determinism: the same `seed` always yields the same deal order.

## Timing
- `shuffle_start` at cycle t:
  - `busy`=1 from t+1.
  - The first candidate is evaluated at t+1 from the loaded seed.
- Minimum shuffle is 52 cycles. Worst case is bounded by 52×(REJECT_MAX+1) cycles.
- `deck_ready` rises the cycle after the 52nd card is written; `busy` falls in that same cycle.
- Deal latency is 1 cycle: registered outputs.
- `deal_req` may be held high: one card per cycle, 52 consecutive `deal_valid` pulses.
- `cards_left` updates in the same cycle as `deal_valid`.
- `deal_card` holds its last value when `deal_valid`=0.

## Structure
- Package `card_pkg`:
  - `CARD_COUNT`=52, `CARD_W`=6, `LFSR_W`=16.
  - Tap positions {15,13,11,10}.
  - `LFSR_ZERO_SUB`=16'h0001.
  - The state enum `dealer_state_t`.
- Sub-module `dealer_lfsr16`:
  - Ports: `clk`, `rst`, `load`, `load_val`, `step`, `q`.
  - Performs the zero-seed substitution on load.
- The top holds the FSM, the used mask, the 52×6 deck register array, the mod-52 mapper and the lowest-unused priority encoder.

## Test plan
- Reset: apply `rst`, release. All outputs are 0, `deal_req` pulses give no `deal_valid`, and state is IDLE.
- Full deal:
  - Stimulus: `seed`=16'hACE1, `shuffle_start`; wait for `deck_ready`; hold `deal_req`.
  - Required: 52 consecutive `deal_valid` pulses; cards form a permutation of 1..52 (sum 1378, no repeats).
  - After the last card: `cards_left`=0 and `deck_empty`=1. A 53rd request gives no valid.
- Determinism and zero seed:
  - Two shuffles with seed 16'h1234 give identical deal sequences.
  - Seed 16'h0000 gives the same sequence as seed 16'h0001.
- Ignored requests: `shuffle_start` pulsed mid-SHUFFLE and `deal_req` held during SHUFFLE. Shuffle completion time is unchanged and no `deal_valid` appears before `deck_ready`.
- Reset mid-operation:
  - `rst` at fill=20 gives IDLE and `busy`=0; a following shuffle with the same seed completes normally.
  - `rst` after 10 deals gives `cards_left`=0 and `deck_ready`=0.
- Fallback path: with REJECT_MAX=1 in a test build, the shuffle still completes with a valid permutation within 104 cycles.
